// File: rtl/key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : key_pulse_gen
// Brief    : Five-lane key synchroniser, debouncer and press-pulse generator
//            with optional per-lane auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module key_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter logic [4:0]  REPEAT_MASK  = 5'b00110
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic [4:0] key_raw,
  output logic [4:0] key_lvl,
  output logic [4:0] key_p,
  output logic       any_p
);

  localparam int unsigned c_num_keys = 5;
  localparam int unsigned c_db_w     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned c_rd_w     = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int unsigned c_rr_w     = (REPEAT_RATE  > 1) ? $clog2(REPEAT_RATE)  : 1;
  // One repeat counter serves both phases, so it must hold the larger compare value.
  localparam int unsigned c_rpt_w    = (c_rd_w > c_rr_w) ? c_rd_w : c_rr_w;

  localparam logic [c_db_w-1:0]  c_db_last    = c_db_w'(DEBOUNCE_CYC - 1);
  localparam logic [c_rpt_w-1:0] c_delay_last = c_rpt_w'(REPEAT_DELAY - 1);
  localparam logic [c_rpt_w-1:0] c_rate_last  = c_rpt_w'(REPEAT_RATE - 1);

  logic [c_num_keys-1:0] w_pulse;
  logic [c_num_keys-1:0] w_stb;
  logic [c_num_keys-1:0] r_key_p;
  logic                  r_any_p;

  generate
    for (genvar gi = 0; gi < c_num_keys; gi++) begin : g_lane
      localparam bit c_rpt_en = REPEAT_MASK[gi];

      logic               r_s1;
      logic               r_s2;
      logic               r_stb;
      logic               r_rpt_ph;
      logic [c_db_w-1:0]  r_db_cnt;
      logic [c_rpt_w-1:0] r_rpt_cnt;
      logic               w_db_hit;
      logic               w_fall;
      logic               w_rpt_hit;

      assign w_db_hit  = (r_s2 != r_stb) && (r_db_cnt == c_db_last);
      assign w_fall    = w_db_hit && r_stb;
      assign w_rpt_hit = c_rpt_en && !r_stb &&
                         (r_rpt_ph ? (r_rpt_cnt == c_rate_last)
                                   : (r_rpt_cnt == c_delay_last));

      always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
          r_s1      <= 1'b1;
          r_s2      <= 1'b1;
          r_stb     <= 1'b1;
          r_db_cnt  <= '0;
          r_rpt_cnt <= '0;
          r_rpt_ph  <= 1'b0;
        end else begin
          r_s1 <= key_raw[gi];
          r_s2 <= r_s1;

          // Any return to the stable level restarts the qualification window.
          if (r_s2 == r_stb) begin
            r_db_cnt <= '0;
          end else if (w_db_hit) begin
            r_db_cnt <= '0;
            r_stb    <= r_s2;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end

          if (!c_rpt_en || r_stb) begin
            r_rpt_cnt <= '0;
            r_rpt_ph  <= 1'b0;
          end else if (w_rpt_hit) begin
            r_rpt_cnt <= '0;
            r_rpt_ph  <= 1'b1;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
          end
        end
      end

      assign w_pulse[gi] = w_fall | w_rpt_hit;
      assign w_stb[gi]   = r_stb;
    end
  endgenerate

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_key_p <= '0;
      r_any_p <= 1'b0;
    end else begin
      r_key_p <= w_pulse;
      r_any_p <= |w_pulse;
    end
  end

  assign key_lvl = w_stb;
  assign key_p   = r_key_p;
  assign any_p   = r_any_p;

endmodule
`default_nettype wire

// File: tb/tb_key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_pulse_gen
// Brief    : Directed self-checking bench for key_pulse_gen (DB=4, RD=20, RR=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_pulse_gen;

  logic       clkin   = 1'b0;
  logic       rst_n   = 1'b0;
  logic [4:0] key_raw = 5'b11111;
  logic [4:0] key_lvl;
  logic [4:0] key_p;
  logic       any_p;

  int errors = 0;
  int checks = 0;

  always #5 clkin = ~clkin;

  key_pulse_gen #(
    .DEBOUNCE_CYC (4),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (8),
    .REPEAT_MASK  (5'b00110)
  ) dut (
    .clkin   (clkin),
    .rst_n   (rst_n),
    .key_raw (key_raw),
    .key_lvl (key_lvl),
    .key_p   (key_p),
    .any_p   (any_p)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    key_raw = 5'b11111;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({key_lvl, key_p, any_p} !== {5'b11111, 5'b00000, 1'b0}) begin
        errors++;
        $display("FAIL reset k=%0d: lvl=%b p=%b any=%b want 11111/00000/0", k, key_lvl, key_p, any_p);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({key_lvl, key_p, any_p} !== {5'b11111, 5'b00000, 1'b0}) begin
        errors++;
        $display("FAIL idle k=%0d: lvl=%b p=%b any=%b want 11111/00000/0", k, key_lvl, key_p, any_p);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] exp_p;
    logic [4:0] exp_lvl;
    key_raw = 5'b11110;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_p   = (k == 6) ? 5'b00001 : 5'b00000;
      exp_lvl = (k >= 6) ? 5'b11110 : 5'b11111;
      checks++;
      if ({key_lvl, key_p, any_p} !== {exp_lvl, exp_p, |exp_p}) begin
        errors++;
        $display("FAIL press_ke k=%0d: lvl=%b p=%b any=%b want %b/%b/%b", k, key_lvl, key_p, any_p, exp_lvl, exp_p, |exp_p);
      end
    end
    key_raw = 5'b11111;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_lvl = (k >= 6) ? 5'b11111 : 5'b11110;
      checks++;
      if ({key_lvl, key_p, any_p} !== {exp_lvl, 5'b00000, 1'b0}) begin
        errors++;
        $display("FAIL release_ke k=%0d: lvl=%b p=%b any=%b want %b/00000/0", k, key_lvl, key_p, any_p, exp_lvl);
      end
    end
  endtask

  task automatic test_bounce();
    logic       lv  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int         len [4] = '{3, 1, 3, 1};
    logic [4:0] exp_p;
    logic [4:0] exp_lvl;
    for (int s = 0; s < 4; s++) begin
      key_raw[1] = lv[s];
      for (int c = 0; c < len[s]; c++) begin
        step();
        checks++;
        if ({key_lvl, key_p, any_p} !== {5'b11111, 5'b00000, 1'b0}) begin
          errors++;
          $display("FAIL bounce seg=%0d: lvl=%b p=%b any=%b want 11111/00000/0", s, key_lvl, key_p, any_p);
        end
      end
    end
    key_raw[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_p   = (k == 6) ? 5'b00010 : 5'b00000;
      exp_lvl = (k >= 6) ? 5'b11101 : 5'b11111;
      checks++;
      if ({key_lvl, key_p, any_p} !== {exp_lvl, exp_p, |exp_p}) begin
        errors++;
        $display("FAIL bounce_steady k=%0d: lvl=%b p=%b any=%b want %b/%b/%b", k, key_lvl, key_p, any_p, exp_lvl, exp_p, |exp_p);
      end
    end
    key_raw = 5'b11111;
    repeat (10) step();
    checks++;
    if ({key_lvl, key_p, any_p} !== {5'b11111, 5'b00000, 1'b0}) begin
      errors++;
      $display("FAIL bounce_settle: lvl=%b p=%b any=%b want 11111/00000/0", key_lvl, key_p, any_p);
    end
  endtask

  task automatic test_auto_repeat();
    logic [4:0] exp_p;
    logic [4:0] exp_lvl;
    bit         hit;
    key_raw[2] = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step();
      hit     = (k == 6) || (k == 26) || (k == 34) || (k == 42) || (k == 50) || (k == 58);
      exp_p   = hit ? 5'b00100 : 5'b00000;
      exp_lvl = (k >= 6 && k < 64) ? 5'b11011 : 5'b11111;
      checks++;
      if ({key_lvl, key_p, any_p} !== {exp_lvl, exp_p, |exp_p}) begin
        errors++;
        $display("FAIL repeat_kd k=%0d: lvl=%b p=%b any=%b want %b/%b/%b", k, key_lvl, key_p, any_p, exp_lvl, exp_p, |exp_p);
      end
      if (k == 58) key_raw = 5'b11111;
    end
  endtask

  task automatic test_no_repeat();
    logic [4:0] exp_p;
    logic [4:0] exp_lvl;
    key_raw[3] = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step();
      exp_p   = (k == 6) ? 5'b01000 : 5'b00000;
      exp_lvl = (k >= 6 && k < 72) ? 5'b10111 : 5'b11111;
      checks++;
      if ({key_lvl, key_p, any_p} !== {exp_lvl, exp_p, |exp_p}) begin
        errors++;
        $display("FAIL norepeat_kl k=%0d: lvl=%b p=%b any=%b want %b/%b/%b", k, key_lvl, key_p, any_p, exp_lvl, exp_p, |exp_p);
      end
      if (k == 66) key_raw = 5'b11111;
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp_p;
    logic [4:0] exp_lvl;
    key_raw = 5'b01110;
    for (int k = 1; k <= 18; k++) begin
      step();
      exp_p   = (k == 6) ? 5'b10001 : 5'b00000;
      exp_lvl = (k >= 6 && k < 16) ? 5'b01110 : 5'b11111;
      checks++;
      if ({key_lvl, key_p, any_p} !== {exp_lvl, exp_p, |exp_p}) begin
        errors++;
        $display("FAIL simul_ke_kr k=%0d: lvl=%b p=%b any=%b want %b/%b/%b", k, key_lvl, key_p, any_p, exp_lvl, exp_p, |exp_p);
      end
      if (k == 10) key_raw = 5'b11111;
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp_p;
    logic [4:0] exp_lvl;
    key_raw[1] = 1'b0;
    // Four edges leave ku's debounce count at 2.
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_lvl, key_p, any_p} !== {5'b11111, 5'b00000, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_async: lvl=%b p=%b any=%b want 11111/00000/0", key_lvl, key_p, any_p);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({key_lvl, key_p, any_p} !== {5'b11111, 5'b00000, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid_hold k=%0d: lvl=%b p=%b any=%b want 11111/00000/0", k, key_lvl, key_p, any_p);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_p   = (k == 6) ? 5'b00010 : 5'b00000;
      exp_lvl = (k >= 6) ? 5'b11101 : 5'b11111;
      checks++;
      if ({key_lvl, key_p, any_p} !== {exp_lvl, exp_p, |exp_p}) begin
        errors++;
        $display("FAIL reset_mid_after k=%0d: lvl=%b p=%b any=%b want %b/%b/%b", k, key_lvl, key_p, any_p, exp_lvl, exp_p, |exp_p);
      end
    end
    key_raw = 5'b11111;
    repeat (10) step();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_no_repeat();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
